// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown sequencer feeding the 7-segment driver (num/dp_in/sw).
// Optional COUNTDOWN_AUTORELOAD_EN: reaching 00 reloads and keeps running, with a one-cycle done pulse.
module countdown_ctrl #(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter logic [7:0]  INIT_VAL  = 8'h60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       key_load,
    input  logic [7:0] load_val,
    output logic [7:0] num,
    output logic [3:0] dp_in,
    output logic [1:0] sw,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DB_W  = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DB_CYCLES - 1);

    localparam logic [3:0] DP_IDLE  = 4'b0000;
    localparam logic [3:0] DP_RUN   = 4'b0010;
    localparam logic [3:0] DP_PAUSE = 4'b0101;
    localparam logic [3:0] DP_DONE  = 4'b1010;

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] res;
        if (v[3:0] != 4'd0) begin
            res = {v[7:4], v[3:0] - 4'd1};
        end else if (v[7:4] != 4'd0) begin
            res = {v[7:4] - 4'd1, 4'd9};
        end else begin
            res = 8'h00;
        end
        return res;
    endfunction

    function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
        units = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {tens, units};
    endfunction

    logic [2:0]      w_keys;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_stable;
    logic [2:0]      r_press;
    logic [DB_W-1:0] r_db_cnt [3];

    assign w_keys = {key_load, key_pause, key_start};

    // Synchronise and debounce the three keys; a press is the registered 0->1 of the stable level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 3'b000;
            r_sync2  <= 3'b000;
            r_stable <= 3'b000;
            r_press  <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= w_keys;
            r_sync2 <= r_sync1;
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] != r_stable[k]) begin
                    if (r_db_cnt[k] == DB_MAX) begin
                        r_stable[k] <= r_sync2[k];
                        r_db_cnt[k] <= '0;
                        r_press[k]  <= r_sync2[k];
                    end else begin
                        r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                        r_press[k]  <= 1'b0;
                    end
                end else begin
                    r_db_cnt[k] <= '0;
                    r_press[k]  <= 1'b0;
                end
            end
        end
    end

    logic       w_cmd_load;
    logic       w_cmd_pause;
    logic       w_cmd_start;
    logic       w_tick;
    logic [7:0] w_load_san;

    // Only the highest-priority press acts: load, then pause, then start.
    assign w_cmd_load  = r_press[2];
    assign w_cmd_pause = r_press[1] & ~r_press[2];
    assign w_cmd_start = r_press[0] & ~r_press[1] & ~r_press[2];
    assign w_load_san  = bcd_clamp(load_val);

    state_t           r_state;
    logic [7:0]       r_num;
    logic [7:0]       r_reload;
    logic [3:0]       r_dp;
    logic             r_done;
    logic [CNT_W-1:0] r_tick_cnt;

    assign w_tick = (r_tick_cnt == TICK_MAX);

    // Main sequencer: state, count value, reload value, tick divider and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_num      <= INIT_VAL;
            r_reload   <= INIT_VAL;
            r_dp       <= DP_IDLE;
            r_done     <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tick_cnt <= '0;
                    if (w_cmd_load) begin
                        r_num    <= w_load_san;
                        r_reload <= w_load_san;
                    end else if (w_cmd_start && (r_num != 8'h00)) begin
                        r_state <= ST_RUN;
                        r_dp    <= DP_RUN;
                    end else begin
                        r_dp <= DP_IDLE;
                    end
                end
                ST_RUN: begin
                    // A press in the same cycle as a tick swallows the tick; the divider holds.
                    if (w_cmd_load) begin
                        r_num      <= w_load_san;
                        r_reload   <= w_load_san;
                        r_state    <= ST_IDLE;
                        r_dp       <= DP_IDLE;
                        r_tick_cnt <= '0;
                    end else if (w_cmd_pause) begin
                        r_state <= ST_PAUSE;
                        r_dp    <= DP_PAUSE;
                    end else if (w_tick) begin
                        r_tick_cnt <= '0;
                        if (r_num == 8'h01) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                            if (r_reload != 8'h00) begin
                                r_num  <= r_reload;
                                r_done <= 1'b1;
                            end else begin
                                r_num   <= 8'h00;
                                r_state <= ST_DONE;
                                r_dp    <= DP_DONE;
                                r_done  <= 1'b1;
                            end
`else
                            r_num   <= 8'h00;
                            r_state <= ST_DONE;
                            r_dp    <= DP_DONE;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_num <= bcd_dec(r_num);
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (w_cmd_load) begin
                        r_num      <= w_load_san;
                        r_reload   <= w_load_san;
                        r_state    <= ST_IDLE;
                        r_dp       <= DP_IDLE;
                        r_tick_cnt <= '0;
                    end else if (w_cmd_pause || w_cmd_start) begin
                        r_state <= ST_RUN;
                        r_dp    <= DP_RUN;
                    end else begin
                        r_dp <= DP_PAUSE;
                    end
                end
                ST_DONE: begin
                    r_tick_cnt <= '0;
                    if (w_cmd_load) begin
                        r_num    <= w_load_san;
                        r_reload <= w_load_san;
                        r_state  <= ST_IDLE;
                        r_dp     <= DP_IDLE;
                    end else if (w_cmd_start) begin
                        r_num <= r_reload;
                        if (r_reload != 8'h00) begin
                            r_state <= ST_RUN;
                            r_dp    <= DP_RUN;
                        end else begin
                            r_state <= ST_IDLE;
                            r_dp    <= DP_IDLE;
                        end
                    end else begin
                        r_done <= 1'b1;
                        r_dp   <= DP_DONE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_dp       <= DP_IDLE;
                    r_tick_cnt <= '0;
                end
            endcase
        end
    end

    assign num   = r_num;
    assign dp_in = r_dp;
    assign sw    = 2'b11;
    assign done  = r_done;
    assign state = r_state;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed self-checking bench for countdown_ctrl with TICK_DIV=4, DB_CYCLES=2.
module tb_countdown_ctrl;

    localparam logic [2:0] K_START = 3'b001;
    localparam logic [2:0] K_PAUSE = 3'b010;
    localparam logic [2:0] K_LOAD  = 3'b100;

    logic       clk;
    logic       rst;
    logic       key_start;
    logic       key_pause;
    logic       key_load;
    logic [7:0] load_val;
    logic [7:0] num;
    logic [3:0] dp_in;
    logic [1:0] sw;
    logic       done;
    logic [1:0] state;

    int n_checks;
    int n_fail;

    countdown_ctrl #(
        .TICK_DIV (4),
        .DB_CYCLES(2),
        .INIT_VAL (8'h60)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_start(key_start),
        .key_pause(key_pause),
        .key_load (key_load),
        .load_val (load_val),
        .num      (num),
        .dp_in    (dp_in),
        .sw       (sw),
        .done     (done),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raw keys rise after a falling edge; the command acts on the 5th rising edge, then keys drop.
    task automatic do_press(input logic [2:0] k);
        @(negedge clk);
        key_start = k[0];
        key_pause = k[1];
        key_load  = k[2];
        repeat (5) @(posedge clk);
        #1;
        key_start = 1'b0;
        key_pause = 1'b0;
        key_load  = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        key_start = 1'b0;
        key_pause = 1'b0;
        key_load  = 1'b0;
        load_val  = 8'h00;

        step(3);
        check_eq("rst_num", num, 8'h60);
        check_eq("rst_state", {6'd0, state}, 8'd0);
        check_eq("rst_dp", {4'd0, dp_in}, 8'h00);
        check_eq("rst_sw", {6'd0, sw}, 8'h03);
        check_eq("rst_done", {7'd0, done}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        step(2);
        check_eq("idle_num", num, 8'h60);
        check_eq("idle_state", {6'd0, state}, 8'd0);

        // Load 12, start, count down through the BCD borrow.
        load_val = 8'h12;
        do_press(K_LOAD);
        check_eq("load12_num", num, 8'h12);
        check_eq("load12_state", {6'd0, state}, 8'd0);
        step(3);
        do_press(K_START);
        check_eq("start_state", {6'd0, state}, 8'd1);
        check_eq("start_dp", {4'd0, dp_in}, 8'h02);
        step(3);
        check_eq("pre_tick_num", num, 8'h12);
        step(1);
        check_eq("tick1_num", num, 8'h11);
        step(4);
        check_eq("tick2_num", num, 8'h10);
        step(4);
        check_eq("borrow_num", num, 8'h09);
        check_eq("run_sw", {6'd0, sw}, 8'h03);

        // Load and start in the same cycle while running: load wins.
        load_val = 8'h37;
        do_press(K_LOAD | K_START);
        check_eq("combo_state", {6'd0, state}, 8'd0);
        check_eq("combo_num", num, 8'h37);
        check_eq("combo_dp", {4'd0, dp_in}, 8'h00);

        // Start with 00 is ignored.
        step(3);
        load_val = 8'h00;
        do_press(K_LOAD);
        check_eq("load00_num", num, 8'h00);
        step(3);
        do_press(K_START);
        check_eq("start00_state", {6'd0, state}, 8'd0);

        // Out-of-range nibbles clamp to 9.
        step(3);
        load_val = 8'hAF;
        do_press(K_LOAD);
        check_eq("clamp_num", num, 8'h99);

        // Bouncy start key must not produce a press.
        step(3);
        @(negedge clk);
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        @(negedge clk);
        key_start = 1'b1;
        @(negedge clk);
        key_start = 1'b0;
        step(8);
        check_eq("glitch_state", {6'd0, state}, 8'd0);
        check_eq("glitch_num", num, 8'h99);

`ifdef COUNTDOWN_AUTORELOAD_EN
        step(3);
        load_val = 8'h01;
        do_press(K_LOAD);
        step(3);
        do_press(K_START);
        check_eq("ar_state", {6'd0, state}, 8'd1);
        step(3);
        check_eq("ar_done_pre", {7'd0, done}, 8'h00);
        step(1);
        check_eq("ar_done_pulse", {7'd0, done}, 8'h01);
        check_eq("ar_num", num, 8'h01);
        check_eq("ar_state_run", {6'd0, state}, 8'd1);
        step(1);
        check_eq("ar_done_low", {7'd0, done}, 8'h00);
        step(3);
        check_eq("ar_done_pulse2", {7'd0, done}, 8'h01);
        check_eq("ar_num2", num, 8'h01);
`else
        // Run 02 to the end, then restart from the reload register.
        step(3);
        load_val = 8'h02;
        do_press(K_LOAD);
        step(3);
        do_press(K_START);
        check_eq("run02_state", {6'd0, state}, 8'd1);
        check_eq("run02_num", num, 8'h02);
        step(6);
        check_eq("run02_mid_num", num, 8'h01);
        check_eq("run02_mid_state", {6'd0, state}, 8'd1);
        step(2);
        check_eq("done_num", num, 8'h00);
        check_eq("done_state", {6'd0, state}, 8'd3);
        check_eq("done_flag", {7'd0, done}, 8'h01);
        check_eq("done_dp", {4'd0, dp_in}, 8'h0A);
        step(1);
        do_press(K_START);
        check_eq("restart_num", num, 8'h02);
        check_eq("restart_state", {6'd0, state}, 8'd1);
        check_eq("restart_done", {7'd0, done}, 8'h00);

        // Pause one cycle into a tick period, hold, resume: the divider carries on.
        step(1);
        do_press(K_PAUSE);
        check_eq("pause_state", {6'd0, state}, 8'd2);
        check_eq("pause_num", num, 8'h01);
        check_eq("pause_dp", {4'd0, dp_in}, 8'h05);
        step(20);
        check_eq("paused_state", {6'd0, state}, 8'd2);
        check_eq("paused_num", num, 8'h01);
        do_press(K_PAUSE);
        check_eq("resume_state", {6'd0, state}, 8'd1);
        check_eq("resume_dp", {4'd0, dp_in}, 8'h02);
        step(2);
        check_eq("resume_hold_num", num, 8'h01);
        step(1);
        check_eq("resume_tick_num", num, 8'h00);
        check_eq("resume_tick_state", {6'd0, state}, 8'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Sequencer for the two-digit 7-segment display driver. Runs a 2-digit BCD countdown timer (00–99) and drives the driver's digit value (num), decimal-point control (dp_in) and enable (sw).
- Takes three raw push-buttons (start, pause, load) plus a BCD preset. Sits between the board keys and the display driver.

Parameters:
- TICK_DIV, 50000000: clk cycles per countdown step (1 s at 50 MHz); must be ≥2.
- DB_CYCLES, 1000000: cycles a synchronised key must hold a new level before it is accepted; must be ≥1.
- INIT_VAL, 8'h60: BCD value loaded at reset.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-low reset.
- key_start, input, 1: raw start key, active high, asynchronous.
- key_pause, input, 1: raw pause/resume key, active high, asynchronous.
- key_load, input, 1: raw load key, active high, asynchronous.
- load_val, input, 8: BCD preset; [7:4] tens, [3:0] units.
- num, output, 8: BCD value to the display driver.
- dp_in, output, 4: decimal-point control to the driver: [3] blink tens, [2] static tens, [1] blink units, [0] static units.
- sw, output, 2: display enable; 2'b11 means show, 2'b00 means blank.
- done, output, 1: high while in DONE.
- state, output, 2: current state; IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, num=INIT_VAL, dp_in=4'b0000, sw=2'b11, done=0. Tick counter, debounce counters and synchronisers are cleared. Reset mid-run abandons the count immediately.
- Key path, per key:
  - 2-flop synchroniser into a stable-level register.
  - The stable level updates only after the synchronised input differs from it for DB_CYCLES consecutive cycles. Any bounce restarts the count.
  - A 0→1 change of the stable level produces a one-cycle press pulse.
  - Press latency is 2+DB_CYCLES+1 cycles after the raw edge.
- Simultaneous presses in one cycle: load wins over pause, and pause wins over start. Only the winner acts.
- Load sanitising: each nibble of load_val above 9 is clamped to 9 (e.g. 8'hA3 loads 8'h93).
- Tick counter:
  - Counts 0..TICK_DIV-1 only in RUN; tick is asserted in the cycle the counter equals TICK_DIV-1, and the counter then wraps to 0.
  - Frozen in PAUSE. Cleared on load, on entry to IDLE and on entry to DONE.
- Decrement on tick: if units≠0, units−1; else units=9 and tens−1. It never wraps below 00.
- FSM (registered; outputs update the cycle after the event):
  - IDLE:
    - load: num=sanitised load_val, stay IDLE.
    - start: if num≠00 go RUN; if num=00 ignore.
    - dp_in=4'b0000.
  - RUN:
    - tick with num=01: num=00, go DONE in the same edge.
    - other tick: decrement.
    - pause: go PAUSE.
    - load: num=sanitised load_val, go IDLE.
    - start: ignored.
    - dp_in=4'b0010 (units dp blinks).
  - PAUSE:
    - pause or start: go RUN, tick counter resumes from its held value.
    - load: num=sanitised load_val, go IDLE.
    - dp_in=4'b0101 (both dps steady on).
  - DONE:
    - done=1, dp_in=4'b1010 (both blink).
    - start: num=last loaded value (reload register, INIT_VAL after reset), go RUN if non-zero, else IDLE.
    - load: num=sanitised load_val, go IDLE.
    - pause: ignored.
- Tick and press in the same cycle: the press has priority and the tick is discarded.
- sw is held at 2'b11 in all states.

Optional Feature:
- Macro: COUNTDOWN_AUTORELOAD_EN.
- Defined: on the tick that reaches 00, num is reloaded from the reload register and state stays RUN. done pulses high for exactly one cycle, and DONE is never entered. A reload value of 00 falls back to the DONE behaviour.
- Undefined: behaviour as in the FSM above; done is a level in DONE.

Test Plan (all scenarios use TICK_DIV=4, DB_CYCLES=2):
- Reset then release: num=8'h60, state=0, dp_in=4'b0000, sw=2'b11, done=0.
- Load 8'h12 in IDLE, then start: num steps 12→11→10→09, one step every 4 cycles. The 10→09 step is a BCD borrow.
- Load 8'h02, start, run to the end: after two ticks num=00, state=3, done=1, dp_in=4'b1010. Press start: num=02, state=1.
- In RUN, press pause 1 cycle into a tick period, hold PAUSE 20 cycles, then resume: the next decrement comes 3 cycles after resume; dp_in=4'b0101 while paused.
- Glitchy key (high 1 cycle, low, high 1 cycle): no press. load_val=8'hAF with a valid load press: num=8'h99.
- Load and start pressed in the same cycle while in RUN: state=0 and num=the loaded value. With COUNTDOWN_AUTORELOAD_EN and load 8'h01: done pulses for one cycle every 4 cycles, num stays 01, state stays 1.
